// File: rtl/seq_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks (sequential adder
// and sequential subtractor): FSM state encoding and counter sizing.
package seq_arith_pkg;

    // State encoding shared by every sequential arithmetic unit, so traces
    // of the adder and subtractor read the same way.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } seq_state_e;

    // Bit-counter width: indexes bits 0..width-1, never narrower than 1.
    function automatic int cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/sequential_subtractor_if.sv
// Operand/result bundle for the sequential subtractor.
// Optional feature macro: SEQ_SUB_OVF_EN adds the signed-overflow flag ovf.
interface sequential_subtractor_if #(parameter int DWIDTH = 8);

    logic [DWIDTH-1:0] in1;
    logic [DWIDTH-1:0] in2;
    logic              ivalid;
    logic [DWIDTH-1:0] Diff;
    logic              Borrow;
    logic              ovalid;
    logic              busy;
`ifdef SEQ_SUB_OVF_EN
    logic              ovf;

    modport master (output in1, in2, ivalid,
                    input  Diff, Borrow, ovalid, busy, ovf);
    modport slave  (input  in1, in2, ivalid,
                    output Diff, Borrow, ovalid, busy, ovf);
`else
    modport master (output in1, in2, ivalid,
                    input  Diff, Borrow, ovalid, busy);
    modport slave  (input  in1, in2, ivalid,
                    output Diff, Borrow, ovalid, busy);
`endif

endinterface

// File: rtl/subtractor_1bit.sv
// One-bit subtract cell: combinational difference plus the registered borrow
// that carries from one serial bit to the next.
module subtractor_1bit (
    input  logic clk,
    input  logic rst,
    input  logic clr,     // start of a new operation: borrow-in becomes 0
    input  logic en,      // a bit is being processed this cycle
    input  logic a,
    input  logic b,
    output logic d,
    output logic borrow   // borrow-in for the current bit / final borrow out
);

    logic bout;

    assign d    = a ^ b ^ borrow;
    assign bout = (~a & b) | (~(a ^ b) & borrow);

    // Borrow flop: cleared per operation, advanced once per processed bit,
    // otherwise held so the final borrow stays visible after the run.
    // NOTE: state updates use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            borrow <= 1'b0;
        else if (clr)
            borrow <= 1'b0;
        else if (en)
            borrow <= bout;
    end

endmodule

// File: rtl/sequential_subtractor.sv
// Bit-serial unsigned subtractor: Diff = in1 - in2, LSB first, one bit per
// clock, with parallel load / ovalid pulse / busy handshake.
// Optional feature macro: SEQ_SUB_OVF_EN (signed overflow flag ovf).
module sequential_subtractor
    import seq_arith_pkg::*;
#(
    parameter int DWIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    sequential_subtractor_if.slave bus
);

    localparam int CNT_W = cnt_width(DWIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DWIDTH - 1);

    seq_state_e        state;
    logic [CNT_W-1:0]  cnt;
    logic              busy_q;
    logic              ovalid_q;
    logic [DWIDTH-1:0] a_q;
    logic [DWIDTH-1:0] b_q;
    logic [DWIDTH-1:0] diff_q;
    logic              d_bit;
    logic              borrow_q;

    logic accept;
    logic run;
    logic last_bit;

    assign accept   = (state == S_IDLE) && bus.ivalid;
    assign run      = (state == S_RUN);
    assign last_bit = run && (cnt == LAST_BIT);

    subtractor_1bit u_cell (
        .clk    (clk),
        .rst    (rst),
        .clr    (accept),
        .en     (run),
        .a      (a_q[0]),
        .b      (b_q[0]),
        .d      (d_bit),
        .borrow (borrow_q)
    );

    // Control FSM with registered busy/ovalid; ivalid outside IDLE is ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            busy_q   <= 1'b0;
            ovalid_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    ovalid_q <= 1'b0;
                    if (bus.ivalid) begin
                        state  <= S_RUN;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (last_bit) begin
                        state    <= S_DONE;
                        ovalid_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    state    <= S_IDLE;
                    ovalid_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
                default: begin
                    state    <= S_IDLE;
                    busy_q   <= 1'b0;
                    ovalid_q <= 1'b0;
                end
            endcase
        end
    end

    // Operand and result shift registers: load on accept, shift during RUN,
    // hold otherwise so Diff stays stable from DONE until the next accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            diff_q <= '0;
        end else if (accept) begin
            a_q    <= bus.in1;
            b_q    <= bus.in2;
            diff_q <= '0;
        end else if (run) begin
            a_q    <= {1'b0, a_q[DWIDTH-1:1]};
            b_q    <= {1'b0, b_q[DWIDTH-1:1]};
            diff_q <= {d_bit, diff_q[DWIDTH-1:1]};
        end
    end

    assign bus.Diff   = diff_q;
    assign bus.Borrow = borrow_q;
    assign bus.ovalid = ovalid_q;
    assign bus.busy   = busy_q;

`ifdef SEQ_SUB_OVF_EN
    logic a_msb;
    logic b_msb;
    logic ovf_q;

    // Signed overflow: operand signs captured on accept, decided when the
    // result MSB is produced on the last serial bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf_q <= 1'b0;
        end else if (accept) begin
            a_msb <= bus.in1[DWIDTH-1];
            b_msb <= bus.in2[DWIDTH-1];
            ovf_q <= 1'b0;
        end else if (last_bit) begin
            ovf_q <= (a_msb != b_msb) && (d_bit != a_msb);
        end
    end

    assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_sequential_subtractor.sv
// Directed self-checking bench for sequential_subtractor (DWIDTH=8).
// Optional feature macro: SEQ_SUB_OVF_EN enables the ovf checks.
module tb_sequential_subtractor;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    sequential_subtractor_if #(.DWIDTH(8)) bus ();

    sequential_subtractor #(.DWIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Issue one operation and follow it through to its ovalid pulse.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] exp_d, input logic exp_b, input logic exp_ovf);
        int lat;
        int bcnt;
        @(negedge clk);
        bus.in1    = a;
        bus.in2    = b;
        bus.ivalid = 1'b1;
        @(posedge clk);
        #1;
        bus.ivalid = 1'b0;
        check({tag, " busy@E0"}, 32'(bus.busy), 32'd1);
        lat  = 0;
        bcnt = 1;
        while (!bus.ovalid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.busy) bcnt++;
        end
        check({tag, " latency"}, 32'(lat), 32'd8);
        check({tag, " busy cycles"}, 32'(bcnt), 32'd9);
        check({tag, " Diff"}, 32'(bus.Diff), 32'(exp_d));
        check({tag, " Borrow"}, 32'(bus.Borrow), 32'(exp_b));
`ifdef SEQ_SUB_OVF_EN
        check({tag, " ovf"}, 32'(bus.ovf), 32'(exp_ovf));
`else
        if (exp_ovf) begin end
`endif
        @(posedge clk);
        #1;
        check({tag, " ovalid drop"}, 32'(bus.ovalid), 32'd0);
        check({tag, " busy drop"}, 32'(bus.busy), 32'd0);
        check({tag, " Diff hold"}, 32'(bus.Diff), 32'(exp_d));
    endtask

    initial begin
        int pulses;
        int lat;
        total      = 0;
        bad        = 0;
        rst        = 1'b1;
        bus.in1    = '0;
        bus.in2    = '0;
        bus.ivalid = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset Diff", 32'(bus.Diff), 32'd0);
        check("reset Borrow", 32'(bus.Borrow), 32'd0);
        check("reset ovalid", 32'(bus.ovalid), 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
`ifdef SEQ_SUB_OVF_EN
        check("reset ovf", 32'(bus.ovf), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // Main function and corner operands
        run_op("5A-1F", 8'h5A, 8'h1F, 8'h3B, 1'b0, 1'b0);
        run_op("10-20", 8'h10, 8'h20, 8'hF0, 1'b1, 1'b0);
        run_op("00-00", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        run_op("FF-FF", 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0);
        run_op("00-01", 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);

        // Busy rejection: extra requests sampled at E3 and E9 are dropped,
        // a request held from E10 is accepted there.
        @(negedge clk);
        bus.in1    = 8'h33;
        bus.in2    = 8'h11;
        bus.ivalid = 1'b1;
        @(posedge clk);
        #1;
        bus.ivalid = 1'b0;
        pulses = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 3 || k == 9) begin
                bus.in1    = 8'hAA;
                bus.in2    = 8'h55;
                bus.ivalid = 1'b1;
            end else if (k == 10) begin
                bus.in1    = 8'h44;
                bus.in2    = 8'h04;
                bus.ivalid = 1'b1;
            end else begin
                bus.ivalid = 1'b0;
            end
            @(posedge clk);
            #1;
            if (bus.ovalid) begin
                pulses++;
                check("busyrej ovalid edge", 32'(k), 32'd8);
                check("busyrej Diff", 32'(bus.Diff), 32'h22);
                check("busyrej Borrow", 32'(bus.Borrow), 32'd0);
            end
            if (k == 9) check("busyrej idle@E9", 32'(bus.busy), 32'd0);
        end
        bus.ivalid = 1'b0;
        check("busyrej pulse count", 32'(pulses), 32'd1);
        check("busyrej accept@E10", 32'(bus.busy), 32'd1);
        lat = 0;
        while (!bus.ovalid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("held latency", 32'(lat), 32'd8);
        check("held Diff", 32'(bus.Diff), 32'h40);
        check("held Borrow", 32'(bus.Borrow), 32'd0);

        // Mid-operation reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.in1    = 8'h80;
        bus.in2    = 8'h01;
        bus.ivalid = 1'b1;
        @(posedge clk);
        #1;
        bus.ivalid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("midrst partial Diff nonzero", 32'(bus.Diff != 8'h00), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst Diff", 32'(bus.Diff), 32'd0);
        check("midrst Borrow", 32'(bus.Borrow), 32'd0);
        check("midrst ovalid", 32'(bus.ovalid), 32'd0);
        check("midrst busy", 32'(bus.busy), 32'd0);
`ifdef SEQ_SUB_OVF_EN
        check("midrst ovf", 32'(bus.ovf), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (bus.ovalid) pulses++;
        end
        check("midrst no ovalid", 32'(pulses), 32'd0);
        run_op("09-03", 8'h09, 8'h03, 8'h06, 1'b0, 1'b0);

`ifdef SEQ_SUB_OVF_EN
        run_op("ovf 80-01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        run_op("ovf 7F-FF", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
        run_op("ovf 05-03", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sequential_subtractor.md
# sequential_subtractor

Bit-serial N-bit unsigned subtractor: computes `Diff = in1 - in2` one bit per clock, LSB first, using a 1-bit subtract cell with a registered borrow and shift registers. It is the inverse-operation companion of the team's sequential adder. It has the same parallel-load / pulse-valid / busy handshake, so it can be used interchangeably in the arithmetic datapath. It is intended for area-constrained paths where DWIDTH-cycle latency is acceptable.

## Interface
- `DWIDTH`, 8, operand/result width in bits; legal range ≥ 2.
- `clk`  input  1  sole clock, rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `in1`  input  DWIDTH  minuend, sampled on accept.
- `in2`  input  DWIDTH  subtrahend, sampled on accept.
- `ivalid`  input  1  operands valid; accepted only when `busy`=0.
- `Diff`  output  DWIDTH  difference `(in1 - in2) mod 2^DWIDTH`.
- `Borrow`  output  1  final borrow out; 1 iff `in1 < in2` (unsigned).
- `ovalid`  output  1  single-cycle pulse; `Diff`/`Borrow` are valid in that cycle.
- `busy`  output  1  operation in progress; `ivalid` is ignored while high.
- `ovf`  output  1  signed overflow; present only with `SEQ_SUB_OVF_EN`.

## Operation
- FSM states:
  - IDLE → RUN on `ivalid`=1.
  - RUN → DONE when the bit counter reaches DWIDTH-1 and that bit is processed.
  - DONE → IDLE unconditionally after one cycle.
- Accept (IDLE, `ivalid`=1):
  - load `in1`/`in2` into the operand shift registers;
  - clear the borrow flop, the `Diff` shift register and the counter;
  - set `busy`.
- RUN, one bit per cycle:
  - cell computes `d = a ^ b ^ bin` and `bout = (~a & b) | (~(a ^ b) & bin)` on operand bit 0;
  - `d` is shifted into `Diff` at the MSB;
  - operands shift right with 0 fill;
  - borrow flop ← `bout`.
- After DWIDTH RUN cycles, `Diff` holds the full result and `Borrow` = last `bout`.
- DONE: `ovalid`=1 for exactly one cycle.
- `Diff`/`Borrow` hold their values from DONE until the next accept. They change during RUN, and their value there is undefined to the consumer.
- `ivalid` in RUN or DONE is dropped: no queuing, no error flag.
- Counter width is `$clog2(DWIDTH)`; the counter never wraps within an operation.
- Reset mid-operation: the in-flight operation is discarded and no `ovalid` is produced.

## Timing
- Reset values: `Diff`=0, `Borrow`=0, `ovalid`=0, `busy`=0, `ovf`=0; state IDLE.
- Accept edge E0: `busy`=1 from E0.
- Bits 0..DWIDTH-1 are processed at edges E1..E_DWIDTH.
- State is DONE and `ovalid`=1 in the cycle after E_DWIDTH.
- At E_DWIDTH+1: `ovalid`=0, `busy`=0, state IDLE.
- Latency: `ovalid` is high DWIDTH cycles after the accept edge.
- Throughput: one operation per DWIDTH+2 cycles.
- Back-to-back: `ivalid` held high is accepted at the first edge where `busy`=0, i.e. E_DWIDTH+2.
- `ovalid` and `busy` are registered outputs with no combinational path from inputs.

## Configuration
- Macro: `SEQ_SUB_OVF_EN`.
- Defined:
  - port `ovf` exists;
  - operand MSBs are captured on accept;
  - `ovf` = `(in1[MSB] != in2[MSB]) && (Diff[MSB] != in1[MSB])` is registered at E_DWIDTH and valid with `ovalid`;
  - `ovf` holds like `Diff` and is cleared on accept.
- Undefined: no `ovf` port and no MSB capture logic; all other behaviour is identical.

## Structure
- Shared package `seq_arith_pkg`:
  - state encoding constants `ST_IDLE`=2'd0, `ST_RUN`=2'd1, `ST_DONE`=2'd2;
  - counter-width helper constant;
  - shared with the sequential adder.
- One sub-module, `subtractor_1bit`: combinational difference/borrow-out plus the borrow flop with synchronous clear on accept and asynchronous reset.
- Operand and result shift registers live inline in the top.

## Test plan
All scenarios use DWIDTH=8.
- `in1`=0x5A, `in2`=0x1F, one-cycle `ivalid` → `ovalid` pulse exactly 8 cycles after the accept edge, `Diff`=0x3B, `Borrow`=0, `busy` high for 9 cycles.
- `in1`=0x10, `in2`=0x20 → `Diff`=0xF0, `Borrow`=1.
- Corner operands:
  - 0x00 − 0x00 → 0x00, `Borrow`=0;
  - 0xFF − 0xFF → 0x00, `Borrow`=0;
  - 0x00 − 0x01 → 0xFF, `Borrow`=1.
- Busy rejection:
  - accept 0x33 − 0x11;
  - pulse `ivalid` with 0xAA/0x55 at cycles 3 and 9 after accept;
  - → one `ovalid` with `Diff`=0x22, second request dropped.
  - Then hold `ivalid` high → accepted at E10 and its result is produced.
- Mid-operation reset:
  - assert `rst` 4 cycles after accepting 0x80 − 0x01 → all outputs 0 immediately, no `ovalid` after release;
  - next op 0x09 − 0x03 → `Diff`=0x06.
- With `SEQ_SUB_OVF_EN`:
  - 0x80 − 0x01 → `Diff`=0x7F, `Borrow`=0, `ovf`=1;
  - 0x7F − 0xFF → `Diff`=0x80, `Borrow`=1, `ovf`=1;
  - 0x05 − 0x03 → `ovf`=0.
